// File: rtl/wb_regfile_unit.sv
// Writeback stage: load extraction, writeback select, 32x32 register file with
// write-through read ports, ecall halt sequencer and retired-writeback counter.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | normal operation; writebacks and retirements are accepted
// HALT  | ecall retired; register file, counter and halt_code are frozen
module wb_regfile_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dm_out_reg,
  input  logic [XLEN-1:0] alu_out_reg,
  input  logic [AW-1:0]   rd_index_reg,
  input  logic            ecall_sig_reg,
  input  logic            wb_sel_reg,
  input  logic            wb_en_reg,
  input  logic [2:0]      func3_reg,
  input  logic [AW-1:0]   rs1_index,
  input  logic [AW-1:0]   rs2_index,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            halt,
  output logic [XLEN-1:0] halt_code,
  output logic [31:0]     retire_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // a0 holds the exit code handed back by ecall
  localparam logic [AW-1:0] A0_IDX = AW'(10);

  state_t          state_q, state_d;
  logic            capture_code;
  logic            we;
  logic            retire;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] a0_val;
  logic [XLEN-1:0] regs [NREG];

  assign off    = alu_out_reg[1:0];
  assign we     = wb_en_reg && (rd_index_reg != '0) && (state_q == RUN);
  assign retire = (state_q == RUN) && (wb_en_reg || ecall_sig_reg);
  assign halt   = (state_q == HALT);

  // Pick the addressed byte/halfword and extend it according to func3
  always_comb begin
    ld_byte = dm_out_reg[7:0];
    case (off)
      2'd0: ld_byte = dm_out_reg[7:0];
      2'd1: ld_byte = dm_out_reg[15:8];
      2'd2: ld_byte = dm_out_reg[23:16];
      2'd3: ld_byte = dm_out_reg[31:24];
      default: ld_byte = dm_out_reg[7:0];
    endcase
    // off[0] is ignored: misaligned halfwords fall back to the aligned one
    ld_half = off[1] ? dm_out_reg[31:16] : dm_out_reg[15:0];
    case (func3_reg)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dm_out_reg;
    endcase
  end

  // Writeback source select
  always_comb begin
    wb_data = wb_sel_reg ? ld_data : alu_out_reg;
  end

  // Read ports with same-cycle write-through bypass; x0 always reads zero
  always_comb begin
    rs1_data = regs[rs1_index];
    rs2_data = regs[rs2_index];
    a0_val   = regs[A0_IDX];
    if (rs1_index == '0) begin
      rs1_data = '0;
    end else if (we && (rs1_index == rd_index_reg)) begin
      rs1_data = wb_data;
    end
    if (rs2_index == '0) begin
      rs2_data = '0;
    end else if (we && (rs2_index == rd_index_reg)) begin
      rs2_data = wb_data;
    end
    // halt_code must see an a0 write retiring alongside the ecall
    if (we && (rd_index_reg == A0_IDX)) begin
      a0_val = wb_data;
    end
  end

  // Halt sequencer next-state
  always_comb begin
    state_d      = state_q;
    capture_code = 1'b0;
    case (state_q)
      RUN: begin
        if (ecall_sig_reg) begin
          state_d      = HALT;
          capture_code = 1'b1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Halt sequencer state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch a0 as the exit code on the retiring ecall
  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_code <= '0;
    end else if (capture_code) begin
      halt_code <= a0_val;
    end
  end

  // Retired-writeback counter; wraps silently
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // Register file storage; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[rd_index_reg] <= wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit: loads, bypass, halt, wrap and reset.
module tb_wb_regfile_unit;

  logic        clk;
  logic        rst;
  logic [31:0] dm_out_reg;
  logic [31:0] alu_out_reg;
  logic [4:0]  rd_index_reg;
  logic        ecall_sig_reg;
  logic        wb_sel_reg;
  logic        wb_en_reg;
  logic [2:0]  func3_reg;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        halt;
  logic [31:0] halt_code;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_regfile_unit #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .dm_out_reg    (dm_out_reg),
    .alu_out_reg   (alu_out_reg),
    .rd_index_reg  (rd_index_reg),
    .ecall_sig_reg (ecall_sig_reg),
    .wb_sel_reg    (wb_sel_reg),
    .wb_en_reg     (wb_en_reg),
    .func3_reg     (func3_reg),
    .rs1_index     (rs1_index),
    .rs2_index     (rs2_index),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_data       (wb_data),
    .halt          (halt),
    .halt_code     (halt_code),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    dm_out_reg    = '0;
    alu_out_reg   = '0;
    rd_index_reg  = '0;
    ecall_sig_reg = 1'b0;
    wb_sel_reg    = 1'b0;
    wb_en_reg     = 1'b0;
    func3_reg     = 3'b010;
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    bubble();
    wb_en_reg    = 1'b1;
    rd_index_reg = rd;
    alu_out_reg  = val;
  endtask

  task automatic load_vec(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] exp);
    bubble();
    dm_out_reg   = 32'h80FF7F01;
    wb_sel_reg   = 1'b1;
    rd_index_reg = 5'd6;
    func3_reg    = f3;
    alu_out_reg  = {30'h0000_1000, off};
    #1;
    check(tag, wb_data, exp);
  endtask

  task automatic read_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    rs1_index = idx;
    rs2_index = idx;
    #1;
    check({tag, "_p1"}, rs1_data, exp);
    check({tag, "_p2"}, rs2_data, exp);
  endtask

  initial begin
    bubble();
    rs1_index = '0;
    rs2_index = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // reset state
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_code", halt_code, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    read_reg("rst_x5", 5'd5, 32'd0);
    read_reg("rst_x31", 5'd31, 32'd0);

    // basic ALU writeback
    alu_write(5'd5, 32'h12345678);
    #1;
    check("wb_alu", wb_data, 32'h12345678);
    tick();
    bubble();
    read_reg("x5", 5'd5, 32'h12345678);
    check("cnt_1", retire_cnt, 32'd1);

    // load extraction on dm_out = 80FF7F01
    load_vec("lb_off3",  3'b000, 2'd3, 32'hFFFFFF80);
    load_vec("lbu_off3", 3'b100, 2'd3, 32'h00000080);
    load_vec("lh_off2",  3'b001, 2'd2, 32'hFFFF80FF);
    load_vec("lhu_off1", 3'b101, 2'd1, 32'h00007F01);
    load_vec("lw",       3'b010, 2'd0, 32'h80FF7F01);
    load_vec("lb_off0",  3'b000, 2'd0, 32'h00000001);
    load_vec("lb_off1",  3'b000, 2'd1, 32'h0000007F);
    load_vec("lb_off2",  3'b000, 2'd2, 32'hFFFFFFFF);
    load_vec("lh_off3",  3'b001, 2'd3, 32'hFFFF80FF);
    load_vec("lhu_off2", 3'b101, 2'd2, 32'h000080FF);
    load_vec("f3_011",   3'b011, 2'd3, 32'h80FF7F01);
    // nothing was written by those vectors
    check("cnt_noload", retire_cnt, 32'd1);

    // actual load writeback into x6
    load_vec("lb_wr", 3'b000, 2'd3, 32'hFFFFFF80);
    wb_en_reg = 1'b1;
    tick();
    bubble();
    read_reg("x6", 5'd6, 32'hFFFFFF80);
    check("cnt_2", retire_cnt, 32'd2);

    // dual bypass
    alu_write(5'd7, 32'hDEADBEEF);
    rs1_index = 5'd7;
    rs2_index = 5'd7;
    #1;
    check("byp_p1", rs1_data, 32'hDEADBEEF);
    check("byp_p2", rs2_data, 32'hDEADBEEF);
    tick();
    // no bypass when write enable is low
    bubble();
    rd_index_reg = 5'd7;
    alu_out_reg  = 32'h0BADF00D;
    read_reg("x7_nobyp", 5'd7, 32'hDEADBEEF);
    check("cnt_3", retire_cnt, 32'd3);

    // write to x0 counts but is discarded
    alu_write(5'd0, 32'h00000055);
    rs1_index = 5'd0;
    #1;
    check("x0_byp", rs1_data, 32'd0);
    tick();
    bubble();
    read_reg("x0", 5'd0, 32'd0);
    check("cnt_x0", retire_cnt, 32'd4);

    // halt on ecall
    alu_write(5'd10, 32'h0000002A);
    tick();
    bubble();
    ecall_sig_reg = 1'b1;
    #1;
    check("halt_pre", {31'b0, halt}, 32'd0);
    tick();
    bubble();
    check("halt", {31'b0, halt}, 32'd1);
    check("halt_code", halt_code, 32'h0000002A);
    check("cnt_ecall", retire_cnt, 32'd6);
    // writes ignored in HALT, no bypass either
    alu_write(5'd3, 32'h00000099);
    rs1_index = 5'd3;
    #1;
    check("halt_nobyp", rs1_data, 32'd0);
    tick();
    ecall_sig_reg = 1'b1;
    alu_write(5'd10, 32'h00000011);
    ecall_sig_reg = 1'b1;
    tick();
    bubble();
    read_reg("halt_x3", 5'd3, 32'd0);
    read_reg("halt_x10", 5'd10, 32'h0000002A);
    check("halt_cnt", retire_cnt, 32'd6);
    check("halt_code_hold", halt_code, 32'h0000002A);
    check("halt_sticky", {31'b0, halt}, 32'd1);

    // reset from HALT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rh_halt", {31'b0, halt}, 32'd0);
    check("rh_code", halt_code, 32'd0);
    check("rh_cnt", retire_cnt, 32'd0);
    read_reg("rh_x10", 5'd10, 32'd0);
    alu_write(5'd3, 32'h00000033);
    tick();
    bubble();
    read_reg("rh_x3", 5'd3, 32'h00000033);

    // ecall together with an a0 write: write lands, halt_code sees it
    alu_write(5'd10, 32'h00000077);
    ecall_sig_reg = 1'b1;
    tick();
    bubble();
    check("ew_halt", {31'b0, halt}, 32'd1);
    check("ew_code", halt_code, 32'h00000077);
    read_reg("ew_x10", 5'd10, 32'h00000077);
    check("ew_cnt", retire_cnt, 32'd2);

    // counter wrap via preload
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dut.retire_cnt = 32'hFFFFFFFF;
    alu_write(5'd1, 32'h00000001);
    tick();
    bubble();
    check("wrap", retire_cnt, 32'd0);
    read_reg("wrap_x1", 5'd1, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
